// File: rtl/washer_plant_model.sv
// Washer plant model: turns washing-machine controller commands into the sensor
// responses that controller expects. It models the door, the water level, detergent
// dispensing, the wash and spin timers, and a sticky protocol-fault flag.
// Optional build macro PLANT_LEAK_EN adds a slow tub leak: one level step is lost
// every LEAK_PERIOD cycles while the fill valve is closed.
module washer_plant_model #(
  parameter int LEVEL_W     = 8,
  parameter int FILL_LEVEL  = 8,
  parameter int DET_DELAY   = 3,
  parameter int WASH_CYCLES = 12,
  parameter int SPIN_CYCLES = 10,
  parameter int LEAK_PERIOD = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               door_req,
  input  logic               door_lock,
  input  logic               motor_on,
  input  logic               fill_value_on,
  input  logic               drain_value_on,
  input  logic               soap_wash,
  input  logic               water_wash,
  input  logic               done,
  output logic               door_close,
  output logic               filled,
  output logic               detergent_added,
  output logic               cycle_timeout,
  output logic               drained,
  output logic               spin_timeout,
  output logic [LEVEL_W-1:0] water_level,
  output logic               fault
);

  localparam logic [LEVEL_W-1:0] FULL     = LEVEL_W'(FILL_LEVEL);
  localparam logic [LEVEL_W-1:0] WASH_LIM = LEVEL_W'(WASH_CYCLES);
  localparam logic [LEVEL_W-1:0] SPIN_LIM = LEVEL_W'(SPIN_CYCLES);
  localparam logic [LEVEL_W-1:0] DET_INIT = LEVEL_W'(DET_DELAY - 1);
  localparam logic [LEVEL_W-1:0] ONE      = LEVEL_W'(1);

  typedef enum logic [1:0] {DOOR_OPEN, DOOR_CLOSED, DOOR_LOCKED} door_t;

  door_t              door_state;
  logic [LEVEL_W-1:0] level_nxt;
  logic [LEVEL_W-1:0] wash_cnt, wash_nxt;
  logic [LEVEL_W-1:0] spin_cnt, spin_nxt;
  logic [LEVEL_W-1:0] det_cnt;
  logic               det_run;
  logic [1:0]         phase, phase_q;
  logic               phase_chg;
  logic               wash_en, spin_en;
  logic               filled_rise, drained_set, fault_cond;

  // Saturating increment toward a limit; never wraps.
  function automatic logic [LEVEL_W-1:0] sat_inc(input logic [LEVEL_W-1:0] v,
                                                 input logic [LEVEL_W-1:0] lim);
    return (v >= lim) ? lim : v + ONE;
  endfunction

  // Saturating decrement with a floor of zero.
  function automatic logic [LEVEL_W-1:0] sat_dec(input logic [LEVEL_W-1:0] v);
    return (v == '0) ? '0 : v - ONE;
  endfunction

`ifdef PLANT_LEAK_EN
  localparam logic [LEVEL_W-1:0] LEAK_LAST = LEVEL_W'(LEAK_PERIOD - 1);
  logic [LEVEL_W-1:0] leak_cnt;
  logic               leak_tick;

  assign leak_tick = (leak_cnt == LEAK_LAST);

  // Free-running leak period counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          leak_cnt <= '0;
    else if (leak_tick) leak_cnt <= '0;
    else                leak_cnt <= leak_cnt + ONE;
  end
`endif

  // Next level, timer next values and event conditions from this cycle's inputs.
  always_comb begin
    level_nxt = water_level;
    if (fill_value_on && !drain_value_on)
      level_nxt = sat_inc(water_level, FULL);
    else if (drain_value_on && !fill_value_on)
      level_nxt = sat_dec(water_level);
`ifdef PLANT_LEAK_EN
    if (leak_tick && !fill_value_on)
      level_nxt = sat_dec(level_nxt);
`endif

    phase     = {soap_wash, water_wash};
    phase_chg = (phase != phase_q);

    // Wash timer pauses (holds) when the tub is not full; a new phase restarts it,
    // with the changing cycle itself counting as the first cycle of the new phase.
    wash_en  = motor_on && (|phase) && (water_level == FULL);
    wash_nxt = wash_cnt;
    if (!motor_on)     wash_nxt = '0;
    else if (phase_chg) wash_nxt = wash_en ? ONE : '0;
    else if (wash_en)   wash_nxt = sat_inc(wash_cnt, WASH_LIM);

    spin_en  = motor_on && drain_value_on && (water_level == '0);
    spin_nxt = spin_cnt;
    if (!motor_on)    spin_nxt = '0;
    else if (spin_en) spin_nxt = sat_inc(spin_cnt, SPIN_LIM);

    // filled and drained track the level being written this cycle, so they line up
    // with water_level on the output.
    filled_rise = (level_nxt == FULL) && !filled;
    drained_set = drain_value_on && !fill_value_on && (level_nxt == '0);

    fault_cond = (fill_value_on && drain_value_on) ||
                 (motor_on && (door_state != DOOR_LOCKED)) ||
                 (door_lock && (door_state == DOOR_OPEN));
  end

  // Door state machine with registered door_close; a lock request on an open door is refused.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      door_state <= DOOR_OPEN;
      door_close <= 1'b0;
    end else begin
      case (door_state)
        DOOR_OPEN: begin
          if (door_req) begin
            door_state <= DOOR_CLOSED;
            door_close <= 1'b1;
          end
        end
        DOOR_CLOSED: begin
          if (door_lock) begin
            door_state <= DOOR_LOCKED;
            door_close <= 1'b1;
          end else if (!door_req) begin
            door_state <= DOOR_OPEN;
            door_close <= 1'b0;
          end
        end
        DOOR_LOCKED: begin
          door_close <= 1'b1;
          if (!door_lock) door_state <= DOOR_CLOSED;
        end
        default: begin
          door_state <= DOOR_OPEN;
          door_close <= 1'b0;
        end
      endcase
    end
  end

  // Water level, level sensors and sticky fault flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      water_level <= '0;
      filled      <= 1'b0;
      drained     <= 1'b0;
      fault       <= 1'b0;
    end else begin
      water_level <= level_nxt;
      filled      <= (level_nxt == FULL);
      if (fill_value_on)    drained <= 1'b0;
      else if (drained_set) drained <= 1'b1;
      if (fault_cond) fault <= 1'b1;
    end
  end

  // Detergent countdown from the rising edge of filled; sticky until drain or done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      detergent_added <= 1'b0;
      det_run         <= 1'b0;
      det_cnt         <= '0;
    end else if (done || drained_set) begin
      detergent_added <= 1'b0;
      det_run         <= 1'b0;
      det_cnt         <= '0;
    end else if (filled_rise && !detergent_added) begin
      det_run <= 1'b1;
      det_cnt <= DET_INIT;
    end else if (det_run) begin
      if (det_cnt == '0) begin
        detergent_added <= 1'b1;
        det_run         <= 1'b0;
      end else begin
        det_cnt <= det_cnt - ONE;
      end
    end
  end

  // Wash and spin timers with their registered timeout flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q       <= 2'b00;
      wash_cnt      <= '0;
      spin_cnt      <= '0;
      cycle_timeout <= 1'b0;
      spin_timeout  <= 1'b0;
    end else begin
      phase_q       <= phase;
      wash_cnt      <= wash_nxt;
      spin_cnt      <= spin_nxt;
      cycle_timeout <= (wash_nxt == WASH_LIM);
      spin_timeout  <= (spin_nxt == SPIN_LIM);
    end
  end

endmodule

// File: tb/tb_washer_plant_model.sv
// Bench for washer_plant_model (default build, leak disabled): table vectors and
// looped sequences push expected outputs to a scoreboard that a monitor checks after each edge.
module tb_washer_plant_model;

  logic       clk = 1'b0;
  logic       reset;
  logic       door_req, door_lock, motor_on, fill_value_on, drain_value_on;
  logic       soap_wash, water_wash, done;
  logic       door_close, filled, detergent_added, cycle_timeout, drained, spin_timeout, fault;
  logic [7:0] water_level;
  logic [14:0] act;

  washer_plant_model dut (
    .clk(clk), .reset(reset), .door_req(door_req), .door_lock(door_lock),
    .motor_on(motor_on), .fill_value_on(fill_value_on), .drain_value_on(drain_value_on),
    .soap_wash(soap_wash), .water_wash(water_wash), .done(done),
    .door_close(door_close), .filled(filled), .detergent_added(detergent_added),
    .cycle_timeout(cycle_timeout), .drained(drained), .spin_timeout(spin_timeout),
    .water_level(water_level), .fault(fault)
  );

  always #5 clk = ~clk;

  // Packed outputs: door_close, filled, detergent, cycle_timeout, drained, spin_timeout, fault, level.
  assign act = {door_close, filled, detergent_added, cycle_timeout, drained, spin_timeout,
                fault, water_level};

  typedef struct {
    string      name;
    bit         rst_before;
    logic [7:0] stim;
    logic [14:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    logic [14:0] exp;
  } sb_t;

  vec_t tbl_door[$];
  vec_t tbl_fault[$];
  sb_t  sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Inputs: door_req, door_lock, motor, fill, drain, soap, water, done.
  function automatic logic [7:0] mi(input bit rq, lk, mo, fi, dr, so, wa, dn);
    return {rq, lk, mo, fi, dr, so, wa, dn};
  endfunction

  function automatic logic [14:0] mx(input bit dc, fl, de, ct, dn, st, ft, input int lvl);
    return {dc, fl, de, ct, dn, st, ft, 8'(lvl)};
  endfunction

  function automatic vec_t mk(input string nm, input bit r, input logic [7:0] s,
                              input logic [14:0] e);
    vec_t v;
    v.name = nm; v.rst_before = r; v.stim = s; v.exp = e;
    return v;
  endfunction

  task automatic set_inputs(input logic [7:0] s);
    {door_req, door_lock, motor_on, fill_value_on, drain_value_on,
     soap_wash, water_wash, done} = s;
  endtask

  task automatic drive(input logic [7:0] s, input logic [14:0] e, input string nm);
    sb_t t;
    @(negedge clk);
    set_inputs(s);
    t.name = nm;
    t.exp  = e;
    sb_q.push_back(t);
  endtask

  // Asynchronous reset between edges; outputs must clear with no clock edge.
  task automatic do_reset(input string nm);
    @(posedge clk);
    #3;
    set_inputs(8'h00);
    reset = 1'b1;
    #1;
    n_tests++;
    if (act !== 15'h0000) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", nm, act, 15'h0000);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    if (v.rst_before) do_reset({v.name, "_reset"});
    drive(v.stim, v.exp, v.name);
  endtask

  // Monitor: compare DUT outputs against the scoreboard just after each rising edge.
  initial begin
    sb_t t;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        t = sb_q.pop_front();
        n_tests++;
        if (act !== t.exp) begin
          n_fail++;
          $display("FAIL %s: got %b, expected %b", t.name, act, t.exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d checks pending", sb_q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl_door.push_back(mk("door_close",      0, mi(1,0,0,0,0,0,0,0), mx(1,0,0,0,0,0,0,0)));
    tbl_door.push_back(mk("door_lock",       0, mi(1,1,0,0,0,0,0,0), mx(1,0,0,0,0,0,0,0)));
    tbl_door.push_back(mk("req_drop_locked", 0, mi(0,1,0,0,0,0,0,0), mx(1,0,0,0,0,0,0,0)));

    tbl_fault.push_back(mk("fill_drain_fault",   0, mi(0,1,0,1,1,0,0,0), mx(1,0,0,0,0,0,1,0)));
    tbl_fault.push_back(mk("fault_sticky",       0, mi(0,1,0,0,0,0,0,0), mx(1,0,0,0,0,0,1,0)));
    tbl_fault.push_back(mk("closed_after_reset", 1, mi(1,0,0,0,0,0,0,0), mx(1,0,0,0,0,0,0,0)));
    tbl_fault.push_back(mk("motor_closed_fault", 0, mi(1,0,1,0,0,0,0,0), mx(1,0,0,0,0,0,1,0)));
    tbl_fault.push_back(mk("motor_off_sticky",   0, mi(1,0,0,0,0,0,0,0), mx(1,0,0,0,0,0,1,0)));
    tbl_fault.push_back(mk("lock_while_open",    1, mi(0,1,0,0,0,0,0,0), mx(0,0,0,0,0,0,1,0)));
    tbl_fault.push_back(mk("open_stays_open",    0, mi(0,0,0,0,0,0,0,0), mx(0,0,0,0,0,0,1,0)));

    reset = 1'b1;
    set_inputs(8'h00);
    do_reset("reset_state");

    foreach (tbl_door[i]) apply(tbl_door[i]);

    // Fill: level climbs to 8 and holds, detergent 3 cycles after filled.
    for (int k = 1; k <= 11; k++)
      drive(mi(0,1,0,1,0,0,0,0), mx(1, k >= 8, k >= 11, 0, 0, 0, 0, (k < 8) ? k : 8), "fill");

    // Soap wash: timeout after 12 counting cycles, then held.
    for (int j = 1; j <= 13; j++)
      drive(mi(0,1,1,0,0,1,0,0), mx(1, 1, 1, j >= 12, 0, 0, 0, 8), "wash_soap");

    // Rinse: phase change clears the timeout and restarts the count.
    for (int j = 1; j <= 12; j++)
      drive(mi(0,1,1,0,0,0,1,0), mx(1, 1, 1, j == 12, 0, 0, 0, 8), "wash_rinse");

    // Drain: level down to 0, drained sets and detergent clears on the same edge.
    for (int d = 1; d <= 8; d++)
      drive(mi(0,1,0,0,1,0,0,0), mx(1, 0, d < 8, 0, d == 8, 0, 0, 8 - d), "drain");

    // Spin: timeout after 10 cycles at empty level with drain open.
    for (int s = 1; s <= 11; s++)
      drive(mi(0,1,1,0,1,0,0,0), mx(1, 0, 0, 0, 1, s >= 10, 0, 0), "spin");
    drive(mi(0,1,0,0,1,0,0,0), mx(1,0,0,0,1,0,0,0), "spin_motor_off");

    foreach (tbl_fault[i]) apply(tbl_fault[i]);

    // Cold start into a wash, then asynchronous reset mid-cycle.
    do_reset("cold_start");
    drive(mi(1,0,0,0,0,0,0,0), mx(1,0,0,0,0,0,0,0), "mw_close");
    drive(mi(1,1,0,0,0,0,0,0), mx(1,0,0,0,0,0,0,0), "mw_lock");
    for (int k = 1; k <= 8; k++)
      drive(mi(0,1,0,1,0,0,0,0), mx(1, k >= 8, 0, 0, 0, 0, 0, k), "mw_fill");
    for (int w = 1; w <= 3; w++)
      drive(mi(0,1,1,0,0,1,0,0), mx(1, 1, (8 + w) >= 11, 0, 0, 0, 0, 8), "mw_wash");
    do_reset("async_reset_midwash");

    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/washer_plant_model.md
Name: washer_plant_model

Overview:
Synthesizable responder for the automatic washing machine controller. It consumes the controller's actuator commands (door lock, valves, motor, wash phase) and produces the sensor inputs that controller expects: door_close, filled, detergent_added, cycle_timeout, drained and spin_timeout. It closes the loop in closed-loop benches and FPGA demos, and adds a water-level model, a door state machine and protocol-fault detection.

Parameters:
LEVEL_W, 8, width of water_level and of all internal timers
FILL_LEVEL, 8, water level at which the tub counts as full (1..2^LEVEL_W-1)
DET_DELAY, 3, cycles from the first filled assertion to detergent_added
WASH_CYCLES, 12, motor-on cycles at full level before cycle_timeout
SPIN_CYCLES, 10, motor-on cycles at empty level with drain open before spin_timeout
LEAK_PERIOD, 16, cycles per leak decrement (used only when PLANT_LEAK_EN is defined)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
door_req  in  1  user/bench intent to close the door (1 = close)
door_lock  in  1  controller command: lock the door
motor_on  in  1  controller command: drum motor
fill_value_on  in  1  controller command: fill valve
drain_value_on  in  1  controller command: drain valve
soap_wash  in  1  controller phase: soap wash
water_wash  in  1  controller phase: rinse
done  in  1  controller: program complete
door_close  out  1  door-closed sensor
filled  out  1  tub-full sensor
detergent_added  out  1  detergent-dispensed sensor
cycle_timeout  out  1  wash/rinse timer expired
drained  out  1  tub-empty-after-drain sensor
spin_timeout  out  1  spin timer expired
water_level  out  LEVEL_W  current modelled level
fault  out  1  sticky protocol-violation flag

Behaviour:
- All outputs are registered. Reset (async, reset=1) drives every output to 0, water_level to 0, the door FSM to OPEN, and all timers to 0.
- Door FSM states and transitions:
  - OPEN -> CLOSED when door_req=1.
  - CLOSED -> LOCKED when door_lock=1.
  - CLOSED -> OPEN when door_req=0.
  - LOCKED -> CLOSED when door_lock=0.
  - In LOCKED, door_req=0 is ignored.
  - door_close=1 in CLOSED and LOCKED. One-cycle latency from input to door_close.
- Water level, per cycle:
  - fill_value_on=1 with drain_value_on=0 and level<FILL_LEVEL: level+1.
  - drain_value_on=1 with fill_value_on=0 and level>0: level-1.
  - Otherwise: hold. Level saturates at 0 and FILL_LEVEL, never wraps.
- filled = (level==FILL_LEVEL), registered.
- drained: set when level==0 while drain_value_on=1. Held until fill_value_on=1. It is not asserted out of reset.
- detergent_added: DET_DELAY-cycle countdown starts on the first cycle filled goes 1. Asserts when the countdown expires and is sticky. Cleared when drained sets or done=1.
- Wash timer:
  - Counts while motor_on=1, (soap_wash|water_wash)=1, and level==FILL_LEVEL.
  - cycle_timeout=1 once count reaches WASH_CYCLES; held until motor_on=0.
  - Timer clears on motor_on=0 and on any change of {soap_wash,water_wash}, so a new phase restarts from 0.
  - Timer saturates, no wrap.
- Spin timer:
  - Counts while motor_on=1, drain_value_on=1, and level==0.
  - spin_timeout=1 at SPIN_CYCLES; held until motor_on=0, which also clears the timer.
- fault: set on any of the following, and cleared only by reset:
  - fill_value_on and drain_value_on both high;
  - motor_on=1 while door FSM is not LOCKED;
  - door_lock=1 while door FSM is OPEN (the lock is refused and the FSM stays OPEN).
- Simultaneous events: a fault cycle still applies the level hold rule. Timers evaluate on the same cycle's inputs.
- Reset mid-operation: all state returns to reset values immediately. The next cycle after release behaves as a cold start.

Optional Feature:
PLANT_LEAK_EN.
- Defined: a free-running LEAK_PERIOD counter decrements level by 1 (floor 0) on each expiry when fill_value_on=0. This can drop filled mid-wash, which pauses the wash timer without clearing it.
- Undefined: no leak; level changes only via the valves. LEAK_PERIOD is unused.

Test Plan:
- Reset, then door_req=1 -> door_close=1 one cycle later. Then door_lock=1 -> LOCKED, fault=0. Drop door_req while locked -> door_close stays 1.
- Fill with defaults: fill_value_on=1 for 8 cycles -> water_level 1..8, filled=1 after the 8th increment. detergent_added=1 exactly 3 cycles after filled rises. Level holds at 8 with fill still on.
- Wash: level=8, motor_on=1, soap_wash=1 -> cycle_timeout=1 after 12 counting cycles. Switching to water_wash clears cycle_timeout and restarts the 12-cycle count.
- Drain/spin: drain_value_on=1 from level 8 -> level 0 after 8 cycles, then drained=1. motor_on=1 -> spin_timeout=1 after 10 cycles. motor_on=0 -> spin_timeout=0.
- Faults: fill and drain both on -> fault=1 and level held. motor_on with the door in CLOSED -> fault=1. fault stays set until reset. Async reset mid-wash -> all outputs 0 without waiting for a clock edge.
- With PLANT_LEAK_EN: full tub, valves off -> level drops to 7 after 16 cycles, filled=0, wash timer pauses.
